uart_word_adapter: RTL and testbench

UART_WORD_ADAPTER -- requirements
Module: uart_word_adapter

---
 rtl/uart_word_adapter_if.sv | 31 +++
 rtl/uart_word_adapter.sv | 134 +++++++++++++
 tb/tb_uart_word_adapter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_word_adapter_if.sv
// Bundles the UART FIFO side and the word side of uart_word_adapter.
// "slave" is the adapter's view and "master" is the surrounding system's view.
interface uart_word_adapter_if #(
   parameter int DATA_BITS  = 8,
   parameter int WORD_BYTES = 4
);
   localparam int W = DATA_BITS * WORD_BYTES;

   logic                 rx_empty;
   logic [DATA_BITS-1:0] r_data;
   logic                 rd_uart;
   logic                 tx_full;
   logic                 wr_uart;
   logic [DATA_BITS-1:0] w_data;
   logic [W-1:0]         rx_word;
   logic                 rx_word_valid;
   logic                 rx_word_ready;
   logic [W-1:0]         tx_word;
   logic                 tx_word_valid;
   logic                 tx_word_ready;

   modport slave (
      input  rx_empty, r_data, tx_full, rx_word_ready, tx_word, tx_word_valid,
      output rd_uart, wr_uart, w_data, rx_word, rx_word_valid, tx_word_ready
   );

   modport master (
      output rx_empty, r_data, tx_full, rx_word_ready, tx_word, tx_word_valid,
      input  rd_uart, wr_uart, w_data, rx_word, rx_word_valid, tx_word_ready
   );
endinterface

// File: rtl/uart_word_adapter.sv
// Packs UART RX bytes into little-endian words and serializes words back into
// UART TX bytes. The RX and TX paths are independent of each other.
module uart_word_adapter #(
   parameter int DATA_BITS  = 8,
   parameter int WORD_BYTES = 4
) (
   input logic                 clk,
   input logic                 reset,
   uart_word_adapter_if.slave  bus
);
   localparam int W     = DATA_BITS * WORD_BYTES;
   localparam int CNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(WORD_BYTES - 1);

   typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} tx_state_e;

   logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [W-1:0]     rx_word_q, rx_word_d;
   logic             rx_valid_q, rx_valid_d;
   logic             rd_uart_s;

   tx_state_e        state_q, state_d;
   logic [W-1:0]     shift_q, shift_d;
   logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
   logic             wr_uart_s;
   logic             tx_ready_s;

   // A held word blocks further pops, so a full word is never overwritten.
   assign rd_uart_s = reset & ~bus.rx_empty & ~rx_valid_q;

   // RX lane write, lane counter and word-valid handshake
   always_comb begin
      rx_cnt_d   = rx_cnt_q;
      rx_word_d  = rx_word_q;
      rx_valid_d = rx_valid_q;
      if (rd_uart_s) begin
         for (int k = 0; k < WORD_BYTES; k++) begin
            if (rx_cnt_q == CNT_W'(k)) begin
               rx_word_d[k*DATA_BITS +: DATA_BITS] = bus.r_data;
            end else begin
               rx_word_d[k*DATA_BITS +: DATA_BITS] = rx_word_q[k*DATA_BITS +: DATA_BITS];
            end
         end
         if (rx_cnt_q == LAST_LANE) begin
            rx_cnt_d   = {CNT_W{1'b0}};
            rx_valid_d = 1'b1;
         end else begin
            rx_cnt_d   = rx_cnt_q + CNT_W'(1);
         end
      end else if (rx_valid_q && bus.rx_word_ready) begin
         rx_valid_d = 1'b0;
      end else begin
         rx_valid_d = rx_valid_q;
      end
   end

   // State register for both paths
   always_ff @(posedge clk) begin
      if (!reset) begin
         rx_cnt_q   <= {CNT_W{1'b0}};
         rx_word_q  <= {W{1'b0}};
         rx_valid_q <= 1'b0;
         state_q    <= IDLE;
         shift_q    <= {W{1'b0}};
         tx_cnt_q   <= {CNT_W{1'b0}};
      end else begin
         rx_cnt_q   <= rx_cnt_d;
         rx_word_q  <= rx_word_d;
         rx_valid_q <= rx_valid_d;
         state_q    <= state_d;
         shift_q    <= shift_d;
         tx_cnt_q   <= tx_cnt_d;
      end
   end

   // TX next state: a stalled SEND cycle (tx_full) leaves everything untouched
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      tx_cnt_d = tx_cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.tx_word_valid) begin
               shift_d  = bus.tx_word;
               tx_cnt_d = {CNT_W{1'b0}};
               state_d  = SEND;
            end else begin
               state_d  = IDLE;
            end
         end
         SEND: begin
            if (!bus.tx_full) begin
               shift_d  = shift_q >> DATA_BITS;
               tx_cnt_d = tx_cnt_q + CNT_W'(1);
               if (tx_cnt_q == LAST_LANE) begin
                  state_d = IDLE;
               end else begin
                  state_d = SEND;
               end
            end else begin
               state_d = SEND;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // TX outputs, all forced inactive while reset is held
   always_comb begin
      wr_uart_s  = 1'b0;
      tx_ready_s = 1'b0;
      case (state_q)
         IDLE: begin
            tx_ready_s = reset;
         end
         SEND: begin
            wr_uart_s = reset & ~bus.tx_full;
         end
         default: begin
            wr_uart_s  = 1'b0;
            tx_ready_s = 1'b0;
         end
      endcase
   end

   assign bus.rd_uart       = rd_uart_s;
   assign bus.rx_word       = rx_word_q;
   assign bus.rx_word_valid = rx_valid_q;
   assign bus.wr_uart       = wr_uart_s;
   assign bus.w_data        = shift_q[DATA_BITS-1:0];
   assign bus.tx_word_ready = tx_ready_s;
endmodule

// File: tb/tb_uart_word_adapter.sv
// Directed self-checking bench for uart_word_adapter with a small RX FIFO model
// and a log of bytes pushed into the TX FIFO.
module tb_uart_word_adapter;
   logic clk;
   logic reset;
   int   checks;
   int   errors;
   logic [7:0] rxq[$];
   logic [7:0] txlog[$];

   uart_word_adapter_if #(.DATA_BITS(8), .WORD_BYTES(4)) bus ();

   uart_word_adapter #(.DATA_BITS(8), .WORD_BYTES(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive_fifo();
      bus.rx_empty = (rxq.size() == 0);
      bus.r_data   = (rxq.size() != 0) ? rxq[0] : 8'h00;
   endtask

   // Samples strobes before the edge, then updates the FIFO models after it.
   task automatic tick();
      logic       rd_seen;
      logic       wr_seen;
      logic [7:0] wb;
      rd_seen = bus.rd_uart;
      wr_seen = bus.wr_uart;
      wb      = bus.w_data;
      @(posedge clk);
      #1;
      if (rd_seen && rxq.size() != 0) void'(rxq.pop_front());
      if (wr_seen) txlog.push_back(wb);
      drive_fifo();
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      rxq.delete();
      rxq.push_back(8'h99);
      bus.tx_full = 1'b0;
      bus.rx_word_ready = 1'b1;
      bus.tx_word = 32'h12345678;
      bus.tx_word_valid = 1'b1;
      drive_fifo();
      tick();
      tick();
      checks++; if (bus.rd_uart !== 1'b0) begin errors++; $display("FAIL reset_rd_uart got %b want 0", bus.rd_uart); end
      checks++; if (bus.wr_uart !== 1'b0) begin errors++; $display("FAIL reset_wr_uart got %b want 0", bus.wr_uart); end
      checks++; if (bus.tx_word_ready !== 1'b0) begin errors++; $display("FAIL reset_tx_ready got %b want 0", bus.tx_word_ready); end
      checks++; if (bus.rx_word_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", bus.rx_word_valid); end
      checks++; if (bus.rx_word !== 32'h0) begin errors++; $display("FAIL reset_rx_word got %h want 00000000", bus.rx_word); end
      checks++; if (rxq.size() != 1) begin errors++; $display("FAIL reset_no_pop got %0d bytes want 1", rxq.size()); end
      rxq.delete();
      bus.tx_word_valid = 1'b0;
      drive_fifo();
      reset = 1'b1;
      #1;
      checks++; if (bus.tx_word_ready !== 1'b1) begin errors++; $display("FAIL post_reset_tx_ready got %b want 1", bus.tx_word_ready); end
      tick();
   endtask

   task automatic test_rx_basic();
      bus.rx_word_ready = 1'b1;
      rxq = '{8'h11, 8'h22, 8'h33, 8'h44};
      drive_fifo();
      #1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (bus.rd_uart !== 1'b1) begin errors++; $display("FAIL rx_basic_rd[%0d] got %b want 1", i, bus.rd_uart); end
         tick();
      end
      checks++; if (bus.rx_word_valid !== 1'b1) begin errors++; $display("FAIL rx_basic_valid got %b want 1", bus.rx_word_valid); end
      checks++; if (bus.rx_word !== 32'h44332211) begin errors++; $display("FAIL rx_basic_word got %h want 44332211", bus.rx_word); end
      checks++; if (bus.rd_uart !== 1'b0) begin errors++; $display("FAIL rx_basic_rd_idle got %b want 0", bus.rd_uart); end
      tick();
      checks++; if (bus.rx_word_valid !== 1'b0) begin errors++; $display("FAIL rx_basic_cleared got %b want 0", bus.rx_word_valid); end
   endtask

   task automatic test_rx_backpressure();
      bus.rx_word_ready = 1'b0;
      rxq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      drive_fifo();
      #1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (bus.rd_uart !== 1'b1) begin errors++; $display("FAIL bp_rd[%0d] got %b want 1", i, bus.rd_uart); end
         tick();
      end
      for (int i = 0; i < 10; i++) begin
         checks++; if (bus.rd_uart !== 1'b0) begin errors++; $display("FAIL bp_hold_rd[%0d] got %b want 0", i, bus.rd_uart); end
         checks++; if (bus.rx_word_valid !== 1'b1 || bus.rx_word !== 32'h04030201) begin
            errors++; $display("FAIL bp_hold_word[%0d] got %b/%h want 1/04030201", i, bus.rx_word_valid, bus.rx_word);
         end
         tick();
      end
      checks++; if (rxq.size() != 4) begin errors++; $display("FAIL bp_pending got %0d want 4", rxq.size()); end
      bus.rx_word_ready = 1'b1;
      #1;
      checks++; if (bus.rd_uart !== 1'b0) begin errors++; $display("FAIL bp_handshake_rd got %b want 0", bus.rd_uart); end
      tick();
      checks++; if (bus.rx_word_valid !== 1'b0 || bus.rd_uart !== 1'b1) begin
         errors++; $display("FAIL bp_resume got valid=%b rd=%b want 0/1", bus.rx_word_valid, bus.rd_uart);
      end
      for (int i = 0; i < 4; i++) tick();
      checks++; if (bus.rx_word_valid !== 1'b1 || bus.rx_word !== 32'h08070605) begin
         errors++; $display("FAIL bp_second_word got %b/%h want 1/08070605", bus.rx_word_valid, bus.rx_word);
      end
      tick();
   endtask

   task automatic test_tx_basic();
      logic [7:0] exp_b [4];
      exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      bus.tx_full = 1'b0;
      bus.tx_word = 32'hDEADBEEF;
      bus.tx_word_valid = 1'b1;
      #1;
      checks++; if (bus.tx_word_ready !== 1'b1 || bus.wr_uart !== 1'b0) begin
         errors++; $display("FAIL tx_idle got ready=%b wr=%b want 1/0", bus.tx_word_ready, bus.wr_uart);
      end
      tick();
      bus.tx_word_valid = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (bus.wr_uart !== 1'b1 || bus.w_data !== exp_b[i] || bus.tx_word_ready !== 1'b0) begin
            errors++; $display("FAIL tx_byte[%0d] got wr=%b data=%h ready=%b want 1/%h/0", i, bus.wr_uart, bus.w_data, bus.tx_word_ready, exp_b[i]);
         end
         tick();
      end
      checks++; if (bus.tx_word_ready !== 1'b1 || bus.wr_uart !== 1'b0) begin
         errors++; $display("FAIL tx_done got ready=%b wr=%b want 1/0", bus.tx_word_ready, bus.wr_uart);
      end
   endtask

   task automatic test_tx_stall();
      logic [7:0] exp_b [4];
      exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      txlog.delete();
      bus.tx_full = 1'b0;
      bus.tx_word = 32'hDEADBEEF;
      bus.tx_word_valid = 1'b1;
      #1;
      tick();
      bus.tx_word_valid = 1'b0;
      tick();
      tick();
      bus.tx_full = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++; if (bus.wr_uart !== 1'b0 || bus.tx_word_ready !== 1'b0) begin
            errors++; $display("FAIL tx_stall[%0d] got wr=%b ready=%b want 0/0", i, bus.wr_uart, bus.tx_word_ready);
         end
         tick();
      end
      bus.tx_full = 1'b0;
      #1;
      tick();
      tick();
      checks++; if (bus.tx_word_ready !== 1'b1) begin errors++; $display("FAIL tx_stall_done got %b want 1", bus.tx_word_ready); end
      checks++; if (txlog.size() != 4) begin errors++; $display("FAIL tx_stall_count got %0d want 4", txlog.size()); end
      for (int i = 0; i < 4; i++) begin
         if (i < txlog.size()) begin
            checks++; if (txlog[i] !== exp_b[i]) begin errors++; $display("FAIL tx_stall_seq[%0d] got %h want %h", i, txlog[i], exp_b[i]); end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_b [4];
      exp_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
      bus.tx_full = 1'b0;
      bus.rx_word_ready = 1'b1;
      bus.tx_word = 32'hA1B2C3D4;
      bus.tx_word_valid = 1'b1;
      rxq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
      drive_fifo();
      #1;
      checks++; if (bus.rd_uart !== 1'b1 || bus.tx_word_ready !== 1'b1) begin
         errors++; $display("FAIL b2b_start got rd=%b ready=%b want 1/1", bus.rd_uart, bus.tx_word_ready);
      end
      tick();
      bus.tx_word_valid = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++; if (bus.rd_uart !== 1'b1 || bus.wr_uart !== 1'b1 || bus.w_data !== exp_b[i]) begin
            errors++; $display("FAIL b2b_cycle[%0d] got rd=%b wr=%b data=%h want 1/1/%h", i, bus.rd_uart, bus.wr_uart, bus.w_data, exp_b[i]);
         end
         tick();
      end
      checks++; if (bus.rd_uart !== 1'b0 || bus.wr_uart !== 1'b1 || bus.w_data !== exp_b[3]) begin
         errors++; $display("FAIL b2b_last got rd=%b wr=%b data=%h want 0/1/a1", bus.rd_uart, bus.wr_uart, bus.w_data);
      end
      checks++; if (bus.rx_word_valid !== 1'b1 || bus.rx_word !== 32'hA3A2A1A0) begin
         errors++; $display("FAIL b2b_word got %b/%h want 1/a3a2a1a0", bus.rx_word_valid, bus.rx_word);
      end
      tick();
      checks++; if (bus.tx_word_ready !== 1'b1 || bus.wr_uart !== 1'b0 || bus.rx_word_valid !== 1'b0) begin
         errors++; $display("FAIL b2b_end got ready=%b wr=%b valid=%b want 1/0/0", bus.tx_word_ready, bus.wr_uart, bus.rx_word_valid);
      end
   endtask

   task automatic test_reset_mid();
      bus.tx_full = 1'b0;
      bus.rx_word_ready = 1'b0;
      bus.tx_word = 32'hCAFEF00D;
      bus.tx_word_valid = 1'b1;
      #1;
      tick();
      bus.tx_word_valid = 1'b0;
      rxq = '{8'h10, 8'h11};
      drive_fifo();
      #1;
      tick();
      tick();
      checks++; if (bus.wr_uart !== 1'b1) begin errors++; $display("FAIL mid_pre_wr got %b want 1", bus.wr_uart); end
      rxq.push_back(8'h99);
      drive_fifo();
      reset = 1'b0;
      #1;
      checks++; if (bus.rd_uart !== 1'b0 || bus.wr_uart !== 1'b0 || bus.tx_word_ready !== 1'b0) begin
         errors++; $display("FAIL mid_gate got rd=%b wr=%b ready=%b want 0/0/0", bus.rd_uart, bus.wr_uart, bus.tx_word_ready);
      end
      tick();
      checks++; if (bus.rx_word_valid !== 1'b0 || bus.rx_word !== 32'h0) begin
         errors++; $display("FAIL mid_rx_clear got %b/%h want 0/00000000", bus.rx_word_valid, bus.rx_word);
      end
      rxq.delete();
      drive_fifo();
      reset = 1'b1;
      #1;
      checks++; if (bus.tx_word_ready !== 1'b1 || bus.wr_uart !== 1'b0 || bus.rd_uart !== 1'b0) begin
         errors++; $display("FAIL mid_release got ready=%b wr=%b rd=%b want 1/0/0", bus.tx_word_ready, bus.wr_uart, bus.rd_uart);
      end
      rxq = '{8'h20, 8'h21, 8'h22, 8'h23};
      drive_fifo();
      #1;
      for (int i = 0; i < 4; i++) tick();
      checks++; if (bus.rx_word_valid !== 1'b1 || bus.rx_word !== 32'h23222120) begin
         errors++; $display("FAIL mid_new_word got %b/%h want 1/23222120", bus.rx_word_valid, bus.rx_word);
      end
      checks++; if (bus.wr_uart !== 1'b0) begin errors++; $display("FAIL mid_no_stale_tx got %b want 0", bus.wr_uart); end
      bus.rx_word_ready = 1'b1;
      #1;
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b0;
      bus.rx_empty = 1'b1;
      bus.r_data = 8'h00;
      bus.tx_full = 1'b0;
      bus.rx_word_ready = 1'b0;
      bus.tx_word = 32'h0;
      bus.tx_word_valid = 1'b0;
      test_reset();
      test_rx_basic();
      test_rx_backpressure();
      test_tx_basic();
      test_tx_stall();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
